// File: rtl/multi_tube_tdc.sv
// multi_tube_tdc: multi-channel drift-tube time-to-digital converter.
// Arms on start, runs one shared cycle counter for the window, latches the
// first synchronised rising edge time per channel, then reads out one word
// per channel in channel order over a valid/ready handshake.
// Optional macro TUBE_EARLY_END_EN: close the window as soon as every
// channel has captured a hit.
module multi_tube_tdc #(
  parameter int unsigned NCH    = 8,
  parameter int unsigned CW     = 8,
  parameter int unsigned WINDOW = 200
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [NCH-1:0]         tube_pins,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic [CW-1:0]          out_time,
  output logic                   out_hit
);

  localparam int unsigned IW = $clog2(NCH);
  localparam logic [CW-1:0] WIN  = CW'(WINDOW);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_READOUT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NCH-1:0]          hit_q, hit_d;
  logic [NCH-1:0][CW-1:0]  time_q, time_d;
  logic [IW-1:0]           rd_idx_q, rd_idx_d;
  logic                    valid_q, valid_d;
  logic [NCH-1:0]          sync1_q, sync1_d;
  logic [NCH-1:0]          sync2_q, sync2_d;
  logic [NCH-1:0]          hist_q, hist_d;
  logic [NCH-1:0]          pin_rise;
  logic                    early_end;

  // Synchroniser and history next values; they track the pins in every state
  always_comb begin
    sync1_d  = tube_pins;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    pin_rise = sync2_q & ~hist_q;
  end

  // Pin synchroniser and history flops
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // Measurement FSM: arm, capture first edges, then sequential readout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    time_d    = time_q;
    rd_idx_d  = rd_idx_q;
    valid_d   = valid_q;
    early_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ARMED;
          cnt_d    = '0;
          hit_d    = '0;
          time_d   = '1;
          rd_idx_d = '0;
        end
      end
      S_ARMED: begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (pin_rise[i] && !hit_q[i]) begin
            hit_d[i]  = 1'b1;
            time_d[i] = cnt_q;
          end
        end
`ifdef TUBE_EARLY_END_EN
        // Uses the post-capture flags so the window closes on the same edge
        // that records the last missing channel.
        early_end = &hit_d;
`else
        early_end = 1'b0;
`endif
        if (cnt_q == WIN || early_end) begin
          state_d  = S_READOUT;
          valid_d  = 1'b1;
          rd_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READOUT: begin
        if (valid_q && out_ready) begin
          if (rd_idx_q == LAST) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM and capture storage registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hit_q    <= '0;
      time_q   <= '0;
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      time_q   <= time_d;
      rd_idx_q <= rd_idx_d;
      valid_q  <= valid_d;
    end
  end

  // Output word is gated by the registered valid so idle outputs read zero
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = valid_q;
    out_ch    = rd_idx_q;
    out_time  = valid_q ? time_q[rd_idx_q] : '0;
    out_hit   = valid_q & hit_q[rd_idx_q];
  end

endmodule

// File: tb/tb_multi_tube_tdc.sv
// Scoreboard bench for multi_tube_tdc: expected words are queued when a
// measurement is armed; a monitor pops and compares each transferred word.
module tb_multi_tube_tdc;

  localparam int NCH = 8;
  localparam int CW  = 8;
  localparam int WIN = 200;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic [NCH-1:0] tube_pins;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_ch;
  logic [CW-1:0]  out_time;
  logic           out_hit;

  typedef struct {
    logic [2:0]    ch;
    logic [CW-1:0] t;
    logic          hit;
  } exp_t;

  typedef struct {
    int c;
    int ch;
    bit v;
  } ev_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;

  multi_tube_tdc #(.NCH(NCH), .CW(CW), .WINDOW(WIN)) dut (
    .clk(clk), .clr(clr), .start(start), .tube_pins(tube_pins),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_time(out_time), .out_hit(out_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready driver: constant high, or the 1,0,0,1 stall pattern
  initial begin
    int k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      if (rdy_mode == 0) out_ready = 1'b1;
      else out_ready = ((k % 4) == 0) || ((k % 4) == 3);
    end
  end

  // Monitor: stability while stalled, and scoreboard compare on transfer
  initial begin
    logic          stalled = 1'b0;
    logic [2:0]    p_ch = '0;
    logic [CW-1:0] p_t = '0;
    logic          p_hit = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_word", {20'd0, out_ch, out_time, out_hit}, {20'd0, p_ch, p_t, p_hit});
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", {29'd0, out_ch}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("word_ch", {29'd0, out_ch}, {29'd0, e.ch});
            chk("word_time", {24'd0, out_time}, {24'd0, e.t});
            chk("word_hit", {31'd0, out_hit}, {31'd0, e.hit});
          end
        end else begin
          stalled = 1'b1;
          p_ch = out_ch;
          p_t = out_time;
          p_hit = out_hit;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_arm", {31'd0, busy}, 32'd1);
  endtask

  // Called just after the arming edge (cnt = 0); applies events after the
  // edge on which cnt becomes c, through cnt = WIN.
  task automatic run_window(input ev_t evs[$]);
    for (int c = 1; c <= WIN; c++) begin
      @(posedge clk);
      #1;
      foreach (evs[k]) if (evs[k].c == c) tube_pins[evs[k].ch] = evs[k].v;
    end
  endtask

  task automatic push_word(input int ch, input int t, input bit h);
    exp_t e;
    e.ch = 3'(ch);
    e.t = CW'(t);
    e.hit = h;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    ev_t evs[$];
    int  c;
    clr = 1'b0;
    start = 1'b0;
    tube_pins = '0;

    // Reset held for 3 cycles with start pulsed meanwhile
    @(posedge clk);
    #1 start = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_ch", {29'd0, out_ch}, 0);
    chk("rst_time", {24'd0, out_time}, 0);
    chk("rst_hit", {31'd0, out_hit}, 0);
    start = 1'b0;
    clr = 1'b1;
    cycles(3);
    chk("rst_start_ignored", {31'd0, busy}, 0);

    // Single hit on ch3 at cnt 10 -> 12; ready held high
    for (int i = 0; i < NCH; i++) push_word(i, (i == 3) ? 12 : 255, i == 3);
    rdy_mode = 0;
    arm();
    evs = '{'{10, 3, 1'b1}};
    run_window(evs);
    wait_drain();
    @(posedge clk);
    #1;
    chk("a_busy_fall", {31'd0, busy}, 0);
    chk("a_valid_fall", {31'd0, out_valid}, 0);

    // Pre-armed ch5, double edges on ch1, boundary hit on ch2, backpressure
    tube_pins = '0;
    tube_pins[5] = 1'b1;
    cycles(4);
    push_word(0, 255, 0);
    push_word(1, 7, 1);
    push_word(2, 200, 1);
    push_word(3, 255, 0);
    push_word(4, 255, 0);
    push_word(5, 42, 1);
    push_word(6, 255, 0);
    push_word(7, 255, 0);
    rdy_mode = 1;
    arm();
    evs = '{'{5, 1, 1'b1}, '{20, 5, 1'b0}, '{30, 1, 1'b0}, '{40, 5, 1'b1},
            '{50, 1, 1'b1}, '{198, 2, 1'b1}};
    run_window(evs);
    c = 0;
    while (!out_valid && c < 10) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("b_readout_entered", {31'd0, out_valid}, 1);
    chk("b_busy_readout", {31'd0, busy}, 1);
    // Pin activity and start during readout must not disturb anything
    tube_pins[0] = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain();
    @(posedge clk);
    #1;
    chk("b_busy_fall", {31'd0, busy}, 0);
    cycles(2);
    chk("b_still_idle", {31'd0, busy}, 0);

    // Mid-window reset
    rdy_mode = 0;
    tube_pins = '0;
    cycles(4);
    arm();
    cycles(5);
    tube_pins[0] = 1'b1;
    cycles(10);
    clr = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_valid", {31'd0, out_valid}, 0);
    @(negedge clk);
    clr = 1'b1;
    tube_pins = '0;
    cycles(4);
    chk("midrst_idle", {31'd0, busy}, 0);

    // Fresh arm: all channels hit at cnt 25 -> 27
    for (int i = 0; i < NCH; i++) push_word(i, 27, 1);
    arm();
    cycles(25);
    tube_pins = '1;
    c = 25;
    while (!out_valid && c < 260) begin
      @(posedge clk);
      #1;
      c++;
    end
`ifdef TUBE_EARLY_END_EN
    chk("early_end_by_33", {31'd0, c <= 33 && c >= 28}, 1);
`else
    chk("full_window_end", c, WIN + 1);
`endif
    wait_drain();
    @(posedge clk);
    #1;
    chk("c_busy_fall", {31'd0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
